lpif_asym2_tx_pair_sched: RTL
=============================

// Module: lpif_asym2_tx_pair_sched
// PURPOSE
// - Upstream TX scheduler for the LPIF asym2 half-rate link. Takes full-rate single-lane LPIF beats and pairs them into one 562-bit txfifo word.
// - Lane0 (bits [0 +: 281]) carries the earlier beat; lane1 (bits [281 +: 281]) carries the later beat.
// - Lone beats are padded with an idle lane1 on flush (and on timeout, if compiled in). Sits between the LPIF adapter TX path and the txfifo_upstream_data packer.
// PARAMETERS
// - BEAT_W   281  one-lane beat width: state[3:0] @0, protid[1:0] @4, data[255:0] @6, dvalid @262, crc[15:0] @263, crc_valid @279, valid @280
// - TIMEOUT  64   idle cycles in S_HALF before auto-pad (used only with the macro)
// - CNT_W    16   width of the pad counter
// PORTS
// - clk_wr         in   1         single clock for all logic
// - rst_wr         in   1         synchronous reset, active-high
// - beat_data      in   BEAT_W    full-rate beat, fields laid out as in BEAT_W
// - beat_vld       in   1         beat_data valid
// - beat_rdy       out  1         beat accepted when beat_vld & beat_rdy
// - flush          in   1         level; pad and emit any held lone beat
// - txfifo_upstream_data out 2*BEAT_W  paired word to txfifo
// - txfifo_vld     out  1         word valid
// - txfifo_rdy     in   1         txfifo can take the word
// - pad_cnt        out  CNT_W     saturating count of padded words emitted
// - busy           out  1         state==S_HALF | txfifo_vld
// BEHAVIOUR
// - All logic is synchronous to clk_wr. rst_wr is synchronous and active-high.
// - Reset values: state=S_HALF cleared to S_EMPTY, hold reg=0, txfifo_vld=0, txfifo_upstream_data=0, pad_cnt=0, timer=0.
// - Output slot free: slot_free = !txfifo_vld | txfifo_rdy.
// - FSM state S_EMPTY (no held beat):
//   - beat_rdy=1.
//   - Accepted beat -> hold reg, next state S_HALF.
//   - flush is a no-op.
// - FSM state S_HALF (lane0 held):
//   - beat_rdy=slot_free.
//   - Accepted beat -> output reg = {beat, hold}; txfifo_vld=1 next cycle; next state S_EMPTY.
//   - Latency: second beat accepted in cycle N -> word visible in cycle N+1.
// - Pad: in S_HALF, if flush=1, no beat is accepted, and slot_free=1:
//   - Output = {pad, hold}; next state S_EMPTY; pad_cnt+1, saturating at all-ones.
//   - pad = lane0 state[3:0] and protid[1:0] copied from the hold reg; all other bits 0, so valid, dvalid and crc_valid are 0.
// - Flush vs beat: flush and an accepted beat in the same cycle -> the pair wins; no pad is emitted.
// - Stall: txfifo_vld=1 & txfifo_rdy=0 -> output reg is held stable, beat_rdy=0 in S_HALF, and no pad is emitted.
// - Handshake: beat_rdy must not depend on beat_vld. txfifo_vld never drops without txfifo_rdy.
// - Back-to-back: with txfifo_rdy tied to 1, the block accepts 1 beat/cycle and emits 1 word every 2 cycles.
// - Reset mid-operation: held beat and pending word are discarded; no pad is emitted.
// CONFIGURATION
// - Macro LPIF_ASYM2_PAD_TIMEOUT_EN.
// - Defined:
//   - timer counts cycles in S_HALF with no accepted beat.
//   - At timer==TIMEOUT-1 an internal flush is asserted, with the same rules as a pad.
//   - timer clears on any state change.
// - Undefined: no timer logic; pads occur only via the flush port. TIMEOUT is ignored.
// STRUCTURE
// - Package lpif_asym2_pkg holds:
//   - BEAT_W;
//   - field offset/width localparams (ST_OFS, PROTID_OFS, DATA_OFS, DVALID_OFS, CRC_OFS, CRCV_OFS, VALID_OFS);
//   - sched_state_e {S_EMPTY, S_HALF};
//   - function mk_pad_beat().
// - Sub-module lpif_asym2_idle_timer: counter plus terminal-count compare. Instantiated only under the macro.
// TESTING
// 1. Reset then two beats A (data=0x11..), B (data=0x22..) on consecutive cycles, txfifo_rdy=1 -> one word, lane0=A, lane1=B, txfifo_vld 1 cycle after B.
// 2. Single beat A (state=4'h3, protid=2'h1), then flush=1 -> word with lane1 state=3, protid=1, bit 561=0; pad_cnt=1.
// 3. Pair completes while txfifo_rdy=0 for 5 cycles -> word stable, beat_rdy=0 in S_HALF, then drains on txfifo_rdy=1.
// 4. flush and second beat in the same cycle -> paired word only, pad_cnt unchanged.
// 5. With macro, TIMEOUT=8: one beat, then idle -> pad word on cycle 8 after acceptance. Without macro -> no word after 100 cycles.
// 6. rst_wr asserted in S_HALF with txfifo_vld=1 -> next cycle txfifo_vld=0, busy=0, pad_cnt=0.

Source files
------------

// File: rtl/lpif_asym2_tx_pair_sched_pkg.sv
// Shared beat layout, scheduler state encoding and the idle-pad helper for the asym2 TX pair scheduler.
package lpif_asym2_pkg;

  localparam int BEAT_W     = 281;
  localparam int ST_OFS     = 0;
  localparam int ST_W       = 4;
  localparam int PROTID_OFS = 4;
  localparam int PROTID_W   = 2;
  localparam int DATA_OFS   = 6;
  localparam int DATA_W     = 256;
  localparam int DVALID_OFS = 262;
  localparam int CRC_OFS    = 263;
  localparam int CRC_W      = 16;
  localparam int CRCV_OFS   = 279;
  localparam int VALID_OFS  = 280;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } sched_state_e;

  // Idle lane1 keeps the link state and protocol id of lane0; valid/dvalid/crc_valid stay 0.
  function automatic beat_t mk_pad_beat(input beat_t held);
    beat_t pad;
    pad = '0;
    pad[ST_OFS +: ST_W]         = held[ST_OFS +: ST_W];
    pad[PROTID_OFS +: PROTID_W] = held[PROTID_OFS +: PROTID_W];
    return pad;
  endfunction

endpackage

// File: rtl/lpif_asym2_tx_pair_sched_if.sv
// Beat input, paired txfifo output and status signals of the asym2 TX pair scheduler.
interface lpif_asym2_tx_pair_sched_if
  import lpif_asym2_pkg::*;
#(
  parameter int CNT_W = 16
);
  beat_t                 beat_data;
  logic                  beat_vld;
  logic                  beat_rdy;
  logic                  flush;
  logic [2*BEAT_W-1:0]   txfifo_upstream_data;
  logic                  txfifo_vld;
  logic                  txfifo_rdy;
  logic [CNT_W-1:0]      pad_cnt;
  logic                  busy;

  modport master (
    output beat_data, beat_vld, flush, txfifo_rdy,
    input  beat_rdy, txfifo_upstream_data, txfifo_vld, pad_cnt, busy
  );

  modport slave (
    input  beat_data, beat_vld, flush, txfifo_rdy,
    output beat_rdy, txfifo_upstream_data, txfifo_vld, pad_cnt, busy
  );
endinterface

// File: rtl/lpif_asym2_tx_pair_sched_timer.sv
// Idle counter for the lone-beat timeout; terminal count is held until cleared.
module lpif_asym2_idle_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_wr,
  input  logic rst_wr,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] r_cnt;

  assign o_tc = (r_cnt == TW'(TIMEOUT - 1));

  // Parking at terminal count keeps the internal flush raised while the output is stalled.
  always_ff @(posedge clk_wr) begin
    if (rst_wr || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/lpif_asym2_tx_pair_sched.sv
// Pairs full-rate LPIF beats into one 2-lane txfifo word; lone beats are padded on flush.
// Optional idle-timeout auto-pad is enabled with macro LPIF_ASYM2_PAD_TIMEOUT_EN.
module lpif_asym2_tx_pair_sched
  import lpif_asym2_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                        clk_wr,
  input  logic                        rst_wr,
  lpif_asym2_tx_pair_sched_if.slave   bus
);
  sched_state_e          r_state;
  sched_state_e          w_state_next;
  beat_t                 r_hold;
  logic [2*BEAT_W-1:0]   r_out;
  logic                  r_vld;
  logic [CNT_W-1:0]      r_pad_cnt;

  logic w_slot_free;
  logic w_beat_rdy;
  logic w_beat_acc;
  logic w_take_pair;
  logic w_take_pad;
  logic w_timer_flush;
  logic w_flush;

  assign w_slot_free = !r_vld || bus.txfifo_rdy;
  assign w_beat_acc  = bus.beat_vld && w_beat_rdy;
  assign w_flush     = bus.flush || w_timer_flush;

`ifdef LPIF_ASYM2_PAD_TIMEOUT_EN
  lpif_asym2_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk_wr (clk_wr),
    .rst_wr (rst_wr),
    .i_en   ((r_state == S_HALF) && !w_beat_acc),
    .i_clr  (w_state_next != r_state),
    .o_tc   (w_timer_flush)
  );
`else
  // No timer in this build: the flush port is the only pad source.
  assign w_timer_flush = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_beat_rdy   = 1'b1;
    w_take_pair  = 1'b0;
    w_take_pad   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (bus.beat_vld) begin
          w_state_next = S_HALF;
        end
      end
      S_HALF: begin
        w_beat_rdy = w_slot_free;
        if (bus.beat_vld && w_slot_free) begin
          w_take_pair  = 1'b1;
          w_state_next = S_EMPTY;
        end else if (w_flush && w_slot_free) begin
          w_take_pad   = 1'b1;
          w_state_next = S_EMPTY;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_hold    <= '0;
      r_out     <= '0;
      r_vld     <= 1'b0;
      r_pad_cnt <= '0;
    end else begin
      if (r_state == S_EMPTY && bus.beat_vld) begin
        r_hold <= bus.beat_data;
      end
      if (w_take_pair) begin
        r_out <= {bus.beat_data, r_hold};
        r_vld <= 1'b1;
      end else if (w_take_pad) begin
        r_out <= {mk_pad_beat(r_hold), r_hold};
        r_vld <= 1'b1;
        if (r_pad_cnt != {CNT_W{1'b1}}) begin
          r_pad_cnt <= r_pad_cnt + 1'b1;
        end
      end else if (bus.txfifo_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign bus.beat_rdy             = w_beat_rdy;
  assign bus.txfifo_upstream_data = r_out;
  assign bus.txfifo_vld           = r_vld;
  assign bus.pad_cnt              = r_pad_cnt;
  assign bus.busy                 = (r_state == S_HALF) || r_vld;
endmodule
